imem_boot_ctrl: RTL and testbench

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

---
 rtl/riscv_ctrl_pkg.sv | 21 ++
 rtl/imem_boot_ctrl_halt_detector.sv | 47 ++++
 rtl/imem_boot_ctrl.sv | 174 +++++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared controller definitions: FSM state encoding, default sizing
// constants and a saturating counter helper.
package riscv_ctrl_pkg;

    localparam int DEF_MAX_WORDS   = 64;
    localparam int DEF_HALT_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } boot_state_t;

    // Increment a 32-bit counter, sticking at all-ones
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/imem_boot_ctrl_halt_detector.sv
// Halt detector: while enabled, samples pc every cycle and counts how many
// consecutive samples equal the previous one. halt is raised combinationally
// on the cycle whose sample completes HALT_CYCLES equal comparisons, so the
// controller can leave RUN on that same clock edge.
module halt_detector
    import riscv_ctrl_pkg::*;
#(
    parameter int HALT_CYCLES = DEF_HALT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] pc,
    output logic        halt
);

    localparam int CNTW = $clog2(HALT_CYCLES + 1);

    logic [31:0]     prev_pc_reg;
    logic            prev_valid_reg;
    logic [CNTW-1:0] count_reg;
    logic            same;

    // The first sample after enable has no predecessor and never counts
    assign same = prev_valid_reg && (pc == prev_pc_reg);
    assign halt = en && same && (count_reg == CNTW'(HALT_CYCLES - 1));

    // Track previous pc and the length of the current equal-sample run
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pc_reg    <= '0;
            prev_valid_reg <= 1'b0;
            count_reg      <= '0;
        end else if (!en) begin
            prev_valid_reg <= 1'b0;
            count_reg      <= '0;
        end else begin
            prev_pc_reg    <= pc;
            prev_valid_reg <= 1'b1;
            if (!same)
                count_reg <= '0;
            else if (count_reg != CNTW'(HALT_CYCLES))
                count_reg <= count_reg + CNTW'(1);
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot controller: streams a host program into CPU
// instruction memory, releases the CPU, and detects halt by a stable pc.
// Optional feature macro IMEM_BOOT_CHECKSUM_EN: one extra host beat carries
// the XOR of all program words; a mismatch ends in ERROR without starting.
module imem_boot_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MAX_WORDS   = DEF_MAX_WORDS,
    parameter int HALT_CYCLES = DEF_HALT_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_req,
    input  logic [$clog2(MAX_WORDS+1)-1:0] word_count,
    input  logic                           abort,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_data,
    output logic [31:0]                    Imem_write_instr,
    output logic [$clog2(MAX_WORDS)-1:0]   Imem_write_addr,
    output logic                           Imem_write_en,
    output logic                           start,
    input  logic [31:0]                    pc,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [31:0]                    run_cycles
);

    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int AW = $clog2(MAX_WORDS);

    boot_state_t   state_reg;
    logic          in_ready_reg;
    logic          write_en_reg;
    logic [31:0]   write_instr_reg;
    logic [AW-1:0] write_addr_reg;
    logic          start_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          error_reg;
    logic [31:0]   run_cycles_reg;
    logic [CW-1:0] addr_cnt_reg;
    logic [CW-1:0] wc_reg;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [31:0]   xsum_reg;
`endif
    logic          halt;

    halt_detector #(
        .HALT_CYCLES (HALT_CYCLES)
    ) u_halt (
        .clk   (clk),
        .reset (reset),
        .en    (state_reg == ST_RUN),
        .pc    (pc),
        .halt  (halt)
    );

    // Boot sequencer with registered outputs; abort overrides everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            in_ready_reg    <= 1'b0;
            write_en_reg    <= 1'b0;
            write_instr_reg <= '0;
            write_addr_reg  <= '0;
            start_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            run_cycles_reg  <= '0;
            addr_cnt_reg    <= '0;
            wc_reg          <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            xsum_reg        <= '0;
`endif
        end else begin
            write_en_reg <= 1'b0;
            if (state_reg == ST_RUN)
                run_cycles_reg <= sat_inc32(run_cycles_reg);

            if (abort) begin
                state_reg    <= ST_IDLE;
                start_reg    <= 1'b0;
                in_ready_reg <= 1'b0;
                busy_reg     <= 1'b0;
                done_reg     <= 1'b0;
                error_reg    <= 1'b0;
            end else begin
                unique case (state_reg)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (load_req) begin
                            done_reg <= 1'b0;
                            if (word_count == '0 || word_count > CW'(MAX_WORDS)) begin
                                state_reg <= ST_ERROR;
                                error_reg <= 1'b1;
                            end else begin
                                state_reg      <= ST_LOAD;
                                error_reg      <= 1'b0;
                                in_ready_reg   <= 1'b1;
                                busy_reg       <= 1'b1;
                                addr_cnt_reg   <= '0;
                                wc_reg         <= word_count;
                                run_cycles_reg <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                                xsum_reg       <= '0;
`endif
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (in_valid && in_ready_reg) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                            if (addr_cnt_reg == wc_reg) begin
                                // Trailing checksum beat: never written to memory
                                in_ready_reg <= 1'b0;
                                if (in_data == xsum_reg) begin
                                    state_reg <= ST_RUN;
                                    start_reg <= 1'b1;
                                end else begin
                                    state_reg <= ST_ERROR;
                                    busy_reg  <= 1'b0;
                                    error_reg <= 1'b1;
                                end
                            end else begin
                                write_instr_reg <= in_data;
                                write_addr_reg  <= addr_cnt_reg[AW-1:0];
                                write_en_reg    <= 1'b1;
                                addr_cnt_reg    <= addr_cnt_reg + CW'(1);
                                xsum_reg        <= xsum_reg ^ in_data;
                            end
`else
                            write_instr_reg <= in_data;
                            write_addr_reg  <= addr_cnt_reg[AW-1:0];
                            write_en_reg    <= 1'b1;
                            addr_cnt_reg    <= addr_cnt_reg + CW'(1);
                            if (addr_cnt_reg == wc_reg - CW'(1))
                                in_ready_reg <= 1'b0;
`endif
                        end
`ifndef IMEM_BOOT_CHECKSUM_EN
                        else if (!in_ready_reg) begin
                            // Last write is on the bus this cycle; release CPU next
                            state_reg <= ST_RUN;
                            start_reg <= 1'b1;
                        end
`endif
                    end
                    ST_RUN: begin
                        if (halt) begin
                            state_reg <= ST_DONE;
                            start_reg <= 1'b0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign in_ready         = in_ready_reg;
    assign Imem_write_en    = write_en_reg;
    assign Imem_write_instr = write_instr_reg;
    assign Imem_write_addr  = write_addr_reg;
    assign start            = start_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign error            = error_reg;
    assign run_cycles       = run_cycles_reg;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Testbench for imem_boot_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_imem_boot_ctrl;
    import riscv_ctrl_pkg::*;

    localparam int MW = 64;
    localparam int HC = 4;
    localparam int CW = $clog2(MW + 1);
    localparam int AW = $clog2(MW);
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DONE = 3, P_ERR = 4;

    logic          clk;
    logic          reset;
    logic          load_req;
    logic [CW-1:0] word_count;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic [31:0]   Imem_write_instr;
    logic [AW-1:0] Imem_write_addr;
    logic          Imem_write_en;
    logic          start;
    logic [31:0]   pc;
    logic          busy;
    logic          done;
    logic          error;
    logic [31:0]   run_cycles;

    imem_boot_ctrl #(.MAX_WORDS(MW), .HALT_CYCLES(HC)) dut (
        .clk              (clk),
        .reset            (reset),
        .load_req         (load_req),
        .word_count       (word_count),
        .abort            (abort),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .Imem_write_instr (Imem_write_instr),
        .Imem_write_addr  (Imem_write_addr),
        .Imem_write_en    (Imem_write_en),
        .start            (start),
        .pc               (pc),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .run_cycles       (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_phase;
    int            m_n;
    int            m_wc;
    logic [31:0]   m_x;
    logic [31:0]   m_rc;
    logic [31:0]   m_instr;
    logic [AW-1:0] m_addr;
    bit            m_we;
    logic [31:0]   pcq[$];

    function automatic bit m_in_ready();
        return (m_phase == P_LOAD) && (m_n < m_wc + CHK);
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_n = 0; m_wc = 0; m_x = '0; m_rc = '0;
        m_instr = '0; m_addr = '0; m_we = 1'b0; pcq.delete();
    endtask

    task automatic model_step();
        int ph;
        bit acc;
        int len;
        ph  = m_phase;
        acc = (ph == P_LOAD) && in_valid && m_in_ready();
        m_we = 1'b0;
        if (ph == P_RUN && m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
        if (abort) begin
            m_phase = P_IDLE;
        end else if (ph == P_IDLE || ph == P_DONE || ph == P_ERR) begin
            if (load_req) begin
                if (word_count == 0 || int'(word_count) > MW) m_phase = P_ERR;
                else begin
                    m_phase = P_LOAD; m_n = 0; m_wc = int'(word_count); m_rc = '0; m_x = '0;
                end
            end
        end else if (ph == P_LOAD) begin
            if (acc && m_n < m_wc) begin
                m_we = 1'b1; m_instr = in_data; m_addr = m_n[AW-1:0];
                m_n++; m_x ^= in_data;
            end else if (acc) begin
                m_phase = (in_data == m_x) ? P_RUN : P_ERR;
                pcq.delete();
            end else if (CHK == 0 && m_n == m_wc) begin
                m_phase = P_RUN;
                pcq.delete();
            end
        end else if (ph == P_RUN) begin
            pcq.push_back(pc);
            len = 0;
            for (int i = pcq.size() - 1; i >= 0; i--) begin
                if (pcq[i] != pc) break;
                len++;
            end
            if (len - 1 >= HC) m_phase = P_DONE;
            if (pcq.size() > HC + 2) void'(pcq.pop_front());
        end
    endtask

    // Model advances on the same edges as the design
    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    // Single compare process: every output, every cycle
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("in_ready",   {31'b0, in_ready},       {31'b0, m_in_ready()});
            chk("write_en",   {31'b0, Imem_write_en},  {31'b0, m_we});
            chk("write_instr", Imem_write_instr,       m_instr);
            chk("write_addr", 32'(Imem_write_addr),    32'(m_addr));
            chk("start",      {31'b0, start},          {31'b0, m_phase == P_RUN});
            chk("busy",       {31'b0, busy},           {31'b0, m_phase == P_LOAD || m_phase == P_RUN});
            chk("done",       {31'b0, done},           {31'b0, m_phase == P_DONE});
            chk("error",      {31'b0, error},          {31'b0, m_phase == P_ERR});
            chk("run_cycles", run_cycles,              m_rc);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {24'b0, in_ready, Imem_write_en, start, busy, done, error, 2'b0}, 32'h0);
        chk({tag, "_instr"}, Imem_write_instr, 32'h0);
        chk({tag, "_addr"}, 32'(Imem_write_addr), 32'h0);
        chk({tag, "_rc"}, run_cycles, 32'h0);
    endtask

    logic [31:0] prog [3];
    logic [31:0] xr;
    logic [31:0] d;
    int k;
    int writes;
    int last_addr;
    int sent;

    initial begin
        prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113; prog[2] = 32'h0000_006F;
        reset = 1'b0; load_req = 1'b0; word_count = '0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; pc = '0;
        model_reset();
        tick();
        chk_all_zero("reset");
        reset = 1'b1;
        cmp_on = 1'b1;
        tick();

        // 3-word load, in_valid held high
        load_req = 1'b1; word_count = CW'(3);
        tick();
        load_req = 1'b0; in_valid = 1'b1; in_data = prog[0]; pc = 32'h8;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("load3_we", {31'b0, Imem_write_en}, 32'h1);
            chk("load3_addr", 32'(Imem_write_addr), i);
            chk("load3_instr", Imem_write_instr, prog[i]);
            if (i < 2) in_data = prog[i + 1];
            else in_data = prog[0] ^ prog[1] ^ prog[2];
        end
        chk("load3_start_early", {31'b0, start}, 32'h0);
        if (CHK == 0) in_valid = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("load3_start", {31'b0, start}, 32'h1);
        chk("load3_we_after", {31'b0, Imem_write_en}, 32'h0);

        // Halt on pc held at 0x8
        k = 0;
        while (!done && k < 50) begin tick(); k++; end
        chk("halt_latency", k, 5);
        chk("halt_start", {31'b0, start}, 32'h0);
        chk("halt_rc", run_cycles, 32'd5);
        repeat (3) tick();
        chk("halt_rc_frozen", run_cycles, 32'd5);
        chk("halt_done_held", {31'b0, done}, 32'h1);

        // Illegal word counts
        load_req = 1'b1; word_count = CW'(0);
        tick();
        load_req = 1'b0;
        chk("wc0_error", {31'b0, error}, 32'h1);
        chk("wc0_we_start", {30'b0, Imem_write_en, start}, 32'h0);
        load_req = 1'b1; word_count = CW'(65);
        tick();
        load_req = 1'b0;
        chk("wc65_error", {31'b0, error}, 32'h1);
        chk("wc65_busy_we_start", {29'b0, busy, Imem_write_en, start}, 32'h0);

        // Abort after the 2nd of 5 beats
        load_req = 1'b1; word_count = CW'(5);
        tick();
        load_req = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5_0001;
        tick();
        in_data = 32'hA5A5_0002;
        tick();
        chk("abort_2nd_write", {31'b0, Imem_write_en}, 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ready", {31'b0, in_ready}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        writes = 0;
        for (int i = 0; i < 4; i++) begin
            writes += int'(Imem_write_en);
            tick();
        end
        chk("abort_no_writes", writes, 0);
        in_valid = 1'b0;

        // Full-size load: addresses 0..63, no wrap
        load_req = 1'b1; word_count = CW'(64);
        tick();
        load_req = 1'b0; in_valid = 1'b1;
        writes = 0; last_addr = -1; sent = 0; xr = '0; k = 0;
        while (!start && k < 200) begin
            if (in_ready) begin
                if (sent < 64) begin
                    d = $urandom; in_data = d; xr ^= d; sent++;
                end else in_data = xr;
            end
            tick();
            k++;
            if (Imem_write_en) begin writes++; last_addr = int'(Imem_write_addr); end
        end
        in_valid = 1'b0;
        chk("full_writes", writes, 64);
        chk("full_last_addr", last_addr, 63);
        chk("full_start", {31'b0, start}, 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

`ifdef IMEM_BOOT_CHECKSUM_EN
        // Checksum good and bad
        for (int t = 0; t < 2; t++) begin
            load_req = 1'b1; word_count = CW'(2);
            tick();
            load_req = 1'b0; in_valid = 1'b1; in_data = 32'h1;
            tick();
            in_data = 32'h2;
            tick();
            in_data = (t == 0) ? 32'h3 : 32'h4;
            tick();
            in_valid = 1'b0;
            chk("cks_start", {31'b0, start}, (t == 0) ? 32'h1 : 32'h0);
            chk("cks_error", {31'b0, error}, (t == 0) ? 32'h0 : 32'h1);
            tick();
            chk("cks_start_hold", {31'b0, start}, (t == 0) ? 32'h1 : 32'h0);
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end
`endif

        // Reset while in RUN
        pc = 32'h40;
        load_req = 1'b1; word_count = CW'(1);
        tick();
        load_req = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0013;
        k = 0;
        while (!start && k < 10) begin tick(); k++; end
        in_valid = 1'b0;
        chk("rst_run_reached", {31'b0, start}, 32'h1);
        pc = 32'h44;
        tick();
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        #2 reset = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            tick();
            load_req = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 15))
                0:       word_count = CW'(0);
                1:       word_count = CW'($urandom_range(65, 127));
                2:       word_count = CW'(64);
                default: word_count = CW'($urandom_range(1, 6));
            endcase
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = $urandom;
            if (CHK == 1 && m_phase == P_LOAD && m_n == m_wc && $urandom_range(0, 1) == 1)
                in_data = m_x;
            abort = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 5) == 0) pc = 32'($urandom_range(0, 3)) * 32'd4;
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                #2 reset = 1'b1;
            end
        end
        tick();
        cmp_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
